// File: rtl/ext_link_pkg.sv
// Shared types and helpers for the ext_serial_link endpoint.
// Holds FSM state enums, default frame length and the parity function.
package ext_link_pkg;

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_PARITY,
    T_STOP,
    T_WAIT_ACK
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_PARITY,
    R_STOP,
    R_ACK
  } rx_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int FRAME_BITS = DEF_DATA_W + 3;

  function automatic int frame_bits(input int dw);
    return dw + 3;
  endfunction

  // Even parity over a zero-extended payload.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ext_link_if.sv
// Local bus side of ext_serial_link: tx/rx valid-ready handshakes.
// master = local bus agent, slave = link endpoint.
interface ext_link_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;
  logic              tx_fail;
  logic [3:0]        retry_cnt;
  logic              rx_en;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_err;
  logic [7:0]        frame_cnt;

  modport master (
    output tx_valid, tx_data, rx_en, rx_ready,
    input  tx_ready, tx_done, tx_fail, retry_cnt,
    input  rx_valid, rx_data, rx_err, frame_cnt
  );

  modport slave (
    input  tx_valid, tx_data, rx_en, rx_ready,
    output tx_ready, tx_done, tx_fail, retry_cnt,
    output rx_valid, rx_data, rx_err, frame_cnt
  );
endinterface

// File: rtl/ext_serial_link_bit_timer.sv
// Free-running CLKS_PER_BIT down-counter with bit strobes.
// Ports: clk, reset, restart (reload), half/full strobes.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic half,
  output logic full
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

  logic [CW-1:0] cnt;

  // full acts one period after restart, half acts CLKS_PER_BIT/2 after.
  assign full = (cnt == '0);
  assign half = (cnt == MID);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= TOP;
    end else if (restart || full) begin
      cnt <= TOP;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/ext_serial_link.sv
// Full-duplex serial link endpoint: parity frames, ack, timeout, retry.
// Ports: clk, reset, bus (ext_link_if.slave), tx_line/rx_line, ack_out/ack_in.
module ext_serial_link
  import ext_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ACK_TIMEOUT  = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic      clk,
  input  logic      reset,
  ext_link_if.slave bus,
  output logic      tx_line,
  input  logic      rx_line,
  output logic      ack_out,
  input  logic      ack_in
);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic rx_s1, rx_s2, rx_s3;
  logic ack_s1, ack_s2;

  // Sync flops reset to line idle so no false start edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_s3  <= 1'b1;
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      rx_s1  <= rx_line;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
      ack_s1 <= ack_in;
      ack_s2 <= ack_s1;
    end
  end

  logic tx_restart, tx_half, tx_full;
  logic rx_restart, rx_half, rx_full;
  logic unused_strobes;

  assign unused_strobes = tx_half ^ rx_full;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (tx_restart),
    .half    (tx_half),
    .full    (tx_full)
  );

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (rx_restart),
    .half    (rx_half),
    .full    (rx_full)
  );

  tx_state_t         tx_state;
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_par;
  logic [5:0]        tx_bit;
  logic [TO_W-1:0]   to_cnt;
  logic              accept;

  assign accept = (tx_state == T_IDLE) && bus.tx_valid && bus.tx_ready;
  assign tx_restart = accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state      <= T_IDLE;
      tx_line       <= 1'b1;
      bus.tx_ready  <= 1'b1;
      bus.tx_done   <= 1'b0;
      bus.tx_fail   <= 1'b0;
      bus.retry_cnt <= '0;
      tx_word       <= '0;
      tx_sh         <= '0;
      tx_par        <= 1'b0;
      tx_bit        <= '0;
      to_cnt        <= '0;
    end else begin
      bus.tx_done <= 1'b0;
      bus.tx_fail <= 1'b0;
      unique case (tx_state)
        T_IDLE: begin
          if (accept) begin
            tx_word       <= bus.tx_data;
            tx_sh         <= bus.tx_data;
            tx_par        <= even_parity(32'(bus.tx_data));
            bus.retry_cnt <= '0;
            bus.tx_ready  <= 1'b0;
            tx_line       <= 1'b0;
            tx_state      <= T_START;
          end
        end
        T_START: begin
          if (tx_full) begin
            tx_line  <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_bit   <= '0;
            tx_state <= T_DATA;
          end
        end
        T_DATA: begin
          if (tx_full) begin
            if (tx_bit == LAST_BIT) begin
              tx_line  <= tx_par;
              tx_state <= T_PARITY;
            end else begin
              tx_line <= tx_sh[0];
              tx_sh   <= tx_sh >> 1;
              tx_bit  <= tx_bit + 6'd1;
            end
          end
        end
        T_PARITY: begin
          if (tx_full) begin
            tx_line  <= 1'b1;
            tx_state <= T_STOP;
          end
        end
        T_STOP: begin
          if (tx_full) begin
            to_cnt   <= '0;
            tx_state <= T_WAIT_ACK;
          end
        end
        T_WAIT_ACK: begin
          if (ack_s2) begin
            bus.tx_done  <= 1'b1;
            bus.tx_ready <= 1'b1;
            tx_state     <= T_IDLE;
          end else if (tx_full) begin
            if (to_cnt == TO_LAST) begin
              if (bus.retry_cnt < 4'(MAX_RETRY)) begin
                // Timer just wrapped, so the resend is bit-aligned.
                bus.retry_cnt <= bus.retry_cnt + 4'd1;
                tx_sh         <= tx_word;
                tx_line       <= 1'b0;
                tx_state      <= T_START;
              end else begin
                bus.tx_fail  <= 1'b1;
                bus.tx_ready <= 1'b1;
                tx_state     <= T_IDLE;
              end
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  rx_state_t         rx_state;
  logic [DATA_W-1:0] rx_sh;
  logic              rx_par;
  logic [5:0]        rx_bit;
  logic              start_edge;
  logic              rx_good;
  logic              rx_free;

  assign start_edge = (rx_state == R_IDLE) && bus.rx_en && rx_s3 && !rx_s2;
  assign rx_restart = start_edge;
  assign rx_good = rx_s2 && (rx_par == even_parity(32'(rx_sh)));
  // A pop on the same cycle frees the buffer for the incoming word.
  assign rx_free = !bus.rx_valid || bus.rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state      <= R_IDLE;
      ack_out       <= 1'b0;
      bus.rx_valid  <= 1'b0;
      bus.rx_data   <= '0;
      bus.rx_err    <= 1'b0;
      bus.frame_cnt <= '0;
      rx_sh         <= '0;
      rx_par        <= 1'b0;
      rx_bit        <= '0;
    end else begin
      bus.rx_err <= 1'b0;
      if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
      unique case (rx_state)
        R_IDLE: begin
          if (start_edge) begin
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (rx_half) begin
            rx_bit   <= '0;
            rx_state <= rx_s2 ? R_IDLE : R_DATA;
          end
        end
        R_DATA: begin
          if (rx_half) begin
            rx_sh <= DATA_W'({rx_s2, rx_sh} >> 1);
            if (rx_bit == LAST_BIT) begin
              rx_state <= R_PARITY;
            end else begin
              rx_bit <= rx_bit + 6'd1;
            end
          end
        end
        R_PARITY: begin
          if (rx_half) begin
            rx_par   <= rx_s2;
            rx_state <= R_STOP;
          end
        end
        R_STOP: begin
          if (rx_half) begin
            if (!rx_good) begin
              bus.rx_err <= 1'b1;
              rx_state   <= R_IDLE;
            end else if (rx_free) begin
              bus.rx_data   <= rx_sh;
              bus.rx_valid  <= 1'b1;
              bus.frame_cnt <= bus.frame_cnt + 8'd1;
              ack_out       <= 1'b1;
              rx_state      <= R_ACK;
            end else begin
              rx_state <= R_IDLE;
            end
          end
        end
        R_ACK: begin
          if (rx_half) begin
            ack_out  <= 1'b0;
            rx_state <= R_IDLE;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ext_serial_link.md
# ext_serial_link

Parametrised full-duplex serial link endpoint for board-to-board traffic between two bus systems over GPIO pins. It replaces the fixed 8-bit, ack-wire link with a configurable frame width, parity-checked frames, acknowledge timeout, bounded retransmission and receive-side backpressure. One instance sits on each side of the link, between the local bus slave's external port and the GPIO pins. Two instances cross-wired (tx_line↔rx_line, ack_out↔ack_in) form a complete link.

## Interface
- DATA_W, 8: payload bits per frame (1..32).
- CLKS_PER_BIT, 16: clk cycles per line bit (≥4).
- ACK_TIMEOUT, 4: bit periods to wait for ack after the stop bit.
- MAX_RETRY, 3: retransmissions before giving up (0..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- tx_valid  in  1  payload offered.
- tx_ready  out  1  high in T_IDLE; a frame is accepted when tx_valid && tx_ready.
- tx_data  in  DATA_W  payload, captured at accept.
- tx_done  out  1  one-cycle pulse when the ack is received.
- tx_fail  out  1  one-cycle pulse when retries are exhausted.
- retry_cnt  out  4  retries used on the current/last frame.
- rx_en  in  1  receiver enable; while low, frames are ignored and never acked.
- rx_valid  out  1  received word held in the buffer.
- rx_ready  in  1  consumer pop; the buffer clears when rx_valid && rx_ready.
- rx_data  out  DATA_W  buffered payload, stable while rx_valid.
- rx_err  out  1  one-cycle pulse on a parity or stop-bit error.
- frame_cnt  out  8  good frames buffered, wraps 255→0.
- tx_line  out  1  serial data out, idle high.
- rx_line  in  1  serial data in (asynchronous).
- ack_out  out  1  ack to far side, idle low.
- ack_in  in  1  ack from far side (asynchronous).

## Operation
- Frame format: start bit (0), then DATA_W data bits LSB first, then an even-parity bit, then a stop bit (1). Frame length is DATA_W+3 bit periods.
- Reset values: tx_line=1, ack_out=0, tx_ready=1, rx_valid=0, rx_data=0, all pulses 0, retry_cnt=0, frame_cnt=0.
- TX FSM:
  - T_IDLE → T_START on accept.
  - T_START → T_DATA → T_PARITY → T_STOP, one bit period each (DATA_W periods for T_DATA).
  - T_STOP → T_WAIT_ACK.
  - T_WAIT_ACK:
    - Synchronised ack_in high → tx_done, go to T_IDLE.
    - Timeout with retry_cnt<MAX_RETRY → increment retry_cnt, go to T_START with the same word.
    - Timeout with retry_cnt=MAX_RETRY → tx_fail, go to T_IDLE.
  - retry_cnt clears on the next accept.
- RX FSM:
  - R_IDLE: falling edge on synchronised rx_line with rx_en=1 → R_START.
  - R_START: resample at half bit. If the line is high (glitch) → R_IDLE; otherwise → R_DATA.
  - R_DATA → R_PARITY → R_STOP, sampling at mid-bit.
  - At the stop sample:
    - Parity/stop error → rx_err, go to R_IDLE, no ack.
    - Good frame with the buffer free → load the buffer, set rx_valid, increment frame_cnt, go to R_ACK.
    - Good frame with the buffer full → drop the frame, no ack (the sender retries).
  - R_ACK: drive ack_out=1 for exactly one bit period, then → R_IDLE.
- If a pop and a good stop sample land on the same cycle, the pop is applied first: the buffer counts as free and the frame is acked.
- rx_en falling mid-frame: the current frame completes normally. rx_en is checked only in R_IDLE.
- TX and RX run independently and simultaneously. Ack reception uses only ack_in.

## Timing
- rx_line and ack_in each pass through a 2-flop synchroniser; effective input latency is 2 cycles.
- tx_line drops on the cycle after accept. Bit edges fall every CLKS_PER_BIT cycles.
- The RX sample point is (CLKS_PER_BIT/2) cycles after the detected start edge, then every CLKS_PER_BIT cycles.
- rx_valid rises 1 cycle after the stop-bit sample. ack_out rises on the same cycle.
- The ack timeout counts ACK_TIMEOUT×CLKS_PER_BIT cycles from entry to T_WAIT_ACK.
- Reset mid-frame: outputs return to idle immediately (asynchronously). No partial frame or pulse is emitted after reset releases.

## Structure
- Shared package `ext_link_pkg` holds:
  - tx_state_t and rx_state_t enums;
  - FRAME_BITS = DATA_W+3;
  - the parity helper function.
- One natural sub-module: `bit_timer`, a CLKS_PER_BIT down-counter with half-period and full-period strobes, instantiated once for TX and once for RX.
- Synchronisers stay inline.

## Test plan
- Loopback pair, DATA_W=8, CLKS_PER_BIT=16: send 0xA5 → far side shows rx_data=0xA5 and frame_cnt=1; near side gets tx_done 11×16 cycles + ack latency later, retry_cnt=0.
- Far side rx_ready held 0, send 0x11 then 0x22 → second frame not acked; retry_cnt reaches 3, then tx_fail. Far side still holds rx_data=0x11.
- Same as above, but pop 0x11 during the first retry → 0x22 is acked with retry_cnt=1.
- Flip the parity bit on the wire → rx_err pulses, no ack; the sender retries and the clean resend succeeds.
- rx_en=0 on the far side → no rx_valid and 4 transmissions total, then tx_fail. Set rx_en=1 and resend → success.
- Assert reset mid-data-bit → tx_line=1, ack_out=0, rx_valid=0 at once. After release, the next frame 0x3C transfers correctly. With DATA_W=12, send 0xABC → rx_data=0xABC.
